alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single-cycle datapath ALU between two requesters, e.g. the instruction-execute path (port 0) and a debug/test access path (port 1). Each request carries operands and a 3-bit operation, and is accepted with a valid/ready handshake. The operands are registered and passed through the ALU in one execute cycle. The result and zero flag are held on a response channel until the granted requester accepts them. Only one operation is in flight at a time.

## Interface
Parameters:
- WIDTH, 32, operand/result width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid / req1_valid  input  1  requester N has an operation.
- req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands A and B.
- req0_op / req1_op  input  3  operation code.
- rsp0_valid / rsp1_valid  output  1  response for requester N is held.
- rsp0_ready / rsp1_ready  input  1  requester N takes its response.
- rsp_result  output  WIDTH  result; shared by both response channels.
- rsp_zero  output  1  1 when rsp_result == 0.
- busy  output  1  state != IDLE.

## Operation
- ALU op encoding (fixed):
  - 000 ADD
  - 100 SUB (A−B)
  - 001 AND
  - 010 OR
  - 101 XOR
  - 110 LUI (B<<16)
  - any other code gives result 0.
- Arithmetic is modulo 2^WIDTH; there is no carry or overflow output.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - When at least one reqN_valid is high, the arbiter picks a winner g.
  - reqg_ready=1 combinationally in the same cycle; the loser's ready stays 0.
  - On the clock edge, the block latches a, b, op into op_a/op_b/op_c, sets grant=g, updates the last-grant pointer and moves to EXEC.
  - With no valid request, the block stays in IDLE.
- EXEC:
  - The ALU computes on the latched operands.
  - The result and zero flag are registered into rsp_result/rsp_zero.
  - Next state is RESP.
- RESP:
  - rsp<grant>_valid=1 and rsp_result/rsp_zero are held stable.
  - When rsp<grant>_ready=1, move to IDLE next edge and drop valid.
  - rsp_ready of the non-granted port is ignored.
- reqN_ready is 0 in every state except IDLE; no new request is accepted while EXEC or RESP is pending.
- A requester may drop valid before it is granted without side effects.
- Reset, including mid-operation:
  - state=IDLE and grant=0, the last-grant pointer points to port 1 (so port 0 wins the first tie).
  - rsp_result=0 and rsp_zero=0.
  - All ready/valid outputs are 0 and busy=0.
  - An in-flight operation is discarded; no response is produced for it.

## Timing
- Accept edge T (valid&ready high before edge T): EXEC during cycle T→T+1. rsp_valid is high from edge T+1.
- Request-to-response latency is 2 cycles; minimum issue interval is 3 cycles (accept, EXEC, RESP with rsp_ready=1 on the first cycle).
- The next accept can occur in the cycle after RESP is left, i.e. IDLE; there is no bypass from RESP to accept.
- All outputs except req*_ready are registered. req*_ready is a function of state, both valids and the pointer.

## Configuration
- ALU_ARB_RR_EN defined:
  - Round-robin. On simultaneous valids, the port not granted last wins.
  - The pointer updates on every accept.
- ALU_ARB_RR_EN undefined:
  - Fixed priority: port 0 always wins a tie.
  - The pointer register is removed. Port 1 may starve while port 0 keeps valid high.

## Test plan
- ADD: port0 a=5, b=3, op=000, rsp0_ready=1 → rsp0_valid 2 cycles after accept, rsp_result=8, rsp_zero=0, rsp1_valid stays 0.
- SUB zero and illegal op:
  - Port1 a=0x7, b=0x7, op=100 → result 0, zero=1.
  - Then op=111, a=0xFFFFFFFF → result 0, zero=1.
- LUI and wrap:
  - op=110, b=0x00001234 → 0x12340000.
  - op=000, a=0xFFFFFFFF, b=2 → 0x00000001.
- Contention, both valid every cycle for 4 ops:
  - With ALU_ARB_RR_EN, grants are 0, 1, 0, 1.
  - Without it, grants are 0, 0, 0, 0.
  - ready is never high on both ports at once.
- Backpressure: hold rsp0_ready=0 for 5 cycles in RESP → rsp0_valid and rsp_result stable, req1_ready=0 throughout; raise rsp0_ready → IDLE next cycle, then port1 accepted.
- Reset mid-op: assert rst_n=0 during EXEC → all outputs 0 immediately (asynchronous), no response after release, and the first tie after release is granted to port 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the shared ALU arbiter and its two requesters.
// The arbiter (slave) owns the ready/response side; requesters (master) own the request side.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned OP_W = 3;

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OP_W-1:0]  req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OP_W-1:0]  req1_op;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single-cycle ALU: accept -> execute -> hold response.
// ALU_ARB_RR_EN selects round-robin tie-breaking; undefined gives fixed priority to port 0.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_AND = 3'b001;
    localparam logic [OP_W-1:0] OP_OR  = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR = 3'b101;
    localparam logic [OP_W-1:0] OP_LUI = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [OP_W-1:0]  r_op_c;
    logic             r_grant;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic             r_busy;

    logic             w_any_valid;
    logic             w_win;
    logic             w_accept;
    logic             w_rsp_fire;
    logic             w_req0_ready;
    logic             w_req1_ready;
    logic [WIDTH-1:0] w_alu_result;

    assign w_any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_RR_EN
    logic r_last;

    // On a tie the port that did not win last time goes next
    always_comb begin
        w_win = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_win = ~r_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_win;
        end
    end
`else
    assign w_win = ~bus.req0_valid;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_valid) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (w_rsp_fire) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake decode; ready is held low while reset is asserted
    always_comb begin
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_accept     = 1'b0;
        w_rsp_fire   = 1'b0;
        if ((r_state == S_IDLE) && w_any_valid && rst_n) begin
            w_accept     = 1'b1;
            w_req0_ready = ~w_win;
            w_req1_ready = w_win;
        end
        if (r_state == S_RESP) begin
            w_rsp_fire = r_grant ? bus.rsp1_ready : bus.rsp0_ready;
        end
    end

    // Single-cycle ALU on the latched operands
    always_comb begin
        w_alu_result = '0;
        case (r_op_c)
            OP_ADD:  w_alu_result = r_op_a + r_op_b;
            OP_SUB:  w_alu_result = r_op_a - r_op_b;
            OP_AND:  w_alu_result = r_op_a & r_op_b;
            OP_OR:   w_alu_result = r_op_a | r_op_b;
            OP_XOR:  w_alu_result = r_op_a ^ r_op_b;
            OP_LUI:  w_alu_result = r_op_b << 16;
            default: w_alu_result = '0;
        endcase
    end

    // Operand capture on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_op_c  <= '0;
            r_grant <= 1'b0;
        end else if (w_accept) begin
            r_op_a  <= w_win ? bus.req1_a  : bus.req0_a;
            r_op_b  <= w_win ? bus.req1_b  : bus.req0_b;
            r_op_c  <= w_win ? bus.req1_op : bus.req0_op;
            r_grant <= w_win;
        end
    end

    // Response registers: result captured in EXEC, flags follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (r_state == S_EXEC) begin
                r_rsp_result <= w_alu_result;
                r_rsp_zero   <= (w_alu_result == '0);
            end
            r_rsp0_valid <= (w_next_state == S_RESP) && !r_grant;
            r_rsp1_valid <= (w_next_state == S_RESP) &&  r_grant;
            r_busy       <= (w_next_state != S_IDLE);
        end
    end

    assign bus.req0_ready = w_req0_ready;
    assign bus.req1_ready = w_req1_ready;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, contention, backpressure,
// mid-operation reset and randomized traffic against a transaction-level model.
module tb_alu_arbiter;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit model_last;

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b100:  return a - b;
            3'b001:  return a & b;
            3'b010:  return a | b;
            3'b101:  return a ^ b;
            3'b110:  return {b[15:0], 16'h0000};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_pick(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
            return model_last ? 0 : 1;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Both ready lines must never be high together
    always @(negedge clk) begin
        if (rst_n) check("ready_exclusive", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
    end

    // One full transaction starting in IDLE; returns at the first IDLE cycle afterwards
    task automatic issue(input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                         input bit keep, input int stall,
                         output int win, output logic [31:0] res, output logic zero);
        logic [31:0] held;
        logic        held_z;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
        win  = model_pick(v0, v1);
        res  = '0;
        zero = 1'b0;
        #1;
        check("req0_ready_idle", 32'(bus.req0_ready), 32'(win == 0));
        check("req1_ready_idle", 32'(bus.req1_ready), 32'(win == 1));
        if (win < 0) begin
            @(posedge clk); #1;
            check("busy_no_req", 32'(bus.busy), 32'd0);
        end else begin
            model_last = (win == 1);
            @(posedge clk); #1;
            if (!keep) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            #1;
            check("busy_exec", 32'(bus.busy), 32'd1);
            check("rsp_valid_exec", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
            check("ready_exec", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
            @(posedge clk); #1;
            check("rsp_valid_resp", 32'({bus.rsp1_valid, bus.rsp0_valid}), (win == 0) ? 32'd1 : 32'd2);
            held   = bus.rsp_result;
            held_z = bus.rsp_zero;
            for (int s = 0; s < stall; s++) begin
                bus.rsp0_ready = (win != 0);
                bus.rsp1_ready = (win != 1);
                @(posedge clk); #1;
                check("rsp_valid_stall", 32'({bus.rsp1_valid, bus.rsp0_valid}), (win == 0) ? 32'd1 : 32'd2);
                check("rsp_result_stall", bus.rsp_result, held);
                check("rsp_zero_stall", 32'(bus.rsp_zero), 32'(held_z));
                check("ready_stall", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
            end
            bus.rsp0_ready = (win == 0);
            bus.rsp1_ready = (win == 1);
            @(posedge clk); #1;
            check("rsp_valid_done", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
            check("busy_done", 32'(bus.busy), 32'd0);
            bus.rsp0_ready = 1'b0;
            bus.rsp1_ready = 1'b0;
            res  = held;
            zero = held_z;
        end
    endtask

    initial begin
        int          w;
        logic [31:0] r;
        logic        z;
        logic [31:0] exp_r;
        bit          rv0, rv1, rkeep;
        logic [31:0] ra0, rb0, ra1, rb1;
        logic [2:0]  rop0, rop1;
        int          grants [4];

        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        rst_n      = 1'b0;
        model_last = 1'b1;

        vecs[0] = '{0, 32'd5,        32'd3,        3'b000, 32'd8,        1'b0};
        vecs[1] = '{1, 32'h7,        32'h7,        3'b100, 32'h0,        1'b1};
        vecs[2] = '{1, 32'hFFFFFFFF, 32'h0,        3'b111, 32'h0,        1'b1};
        vecs[3] = '{0, 32'hDEADBEEF, 32'h00001234, 3'b110, 32'h12340000, 1'b0};
        vecs[4] = '{0, 32'hFFFFFFFF, 32'd2,        3'b000, 32'h00000001, 1'b0};
        vecs[5] = '{1, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 32'h00F000F0, 1'b0};
        vecs[6] = '{0, 32'h12340000, 32'h00005678, 3'b010, 32'h12345678, 1'b0};
        vecs[7] = '{1, 32'hFFFF0000, 32'h0F0F0F0F, 3'b101, 32'hF0F00F0F, 1'b0};
        vecs[8] = '{0, 32'h11111111, 32'h22222222, 3'b011, 32'h0,        1'b1};
        vecs[9] = '{1, 32'd3,        32'd5,        3'b100, 32'hFFFFFFFE, 1'b0};

`ifdef ALU_ARB_RR_EN
        grants = '{0, 1, 0, 1};
`else
        grants = '{0, 0, 0, 0};
`endif

        #2;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        check("reset_result", bus.rsp_result, 32'd0);
        check("reset_zero", 32'(bus.rsp_zero), 32'd0);
        check("reset_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].port == 0, vecs[i].port == 1,
                  vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].op,
                  1'b0, i % 3, w, r, z);
            check("vec_result", r, vecs[i].exp_res);
            check("vec_zero", 32'(z), 32'(vecs[i].exp_zero));
        end

        // Contention: both ports valid every cycle; results identify the winner
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b1, 32'd1, 32'd1, 3'b000, 32'd10, 32'd10, 3'b000,
                  1'b1, 0, w, r, z);
            check("contention_grant", r, (grants[i] == 0) ? 32'd2 : 32'd20);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Backpressure with port 1 waiting, then port 1 accepted straight after
        issue(1'b1, 1'b1, 32'hAAAA5555, 32'hFFFF0000, 3'b101, 32'h00FF0000, 32'h000000FF, 3'b010,
              1'b1, 5, w, r, z);
        check("backpressure_result", r, 32'h55555555);
        issue(1'b0, 1'b1, 32'h0, 32'h0, 3'b000, 32'h00FF0000, 32'h000000FF, 3'b010,
              1'b0, 0, w, r, z);
        check("after_backpressure_p1", r, 32'h00FF00FF);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            rv0   = ($urandom_range(0, 3) != 0);
            rv1   = ($urandom_range(0, 3) != 0);
            rkeep = 1'($urandom_range(0, 1));
            ra0 = $urandom; rb0 = (i % 5 == 0) ? ra0 : $urandom; rop0 = 3'($urandom_range(0, 7));
            ra1 = $urandom; rb1 = (i % 7 == 0) ? ra1 : $urandom; rop1 = 3'($urandom_range(0, 7));
            issue(rv0, rv1, ra0, rb0, rop0, ra1, rb1, rop1, rkeep, $urandom_range(0, 3), w, r, z);
            if (w >= 0) begin
                exp_r = (w == 0) ? model_alu(ra0, rb0, rop0) : model_alu(ra1, rb1, rop1);
                check("rand_result", r, exp_r);
                check("rand_zero", 32'(z), 32'(exp_r == 32'h0));
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Reset during EXEC: port 0 granted last, so a stale pointer would favour port 1
        issue(1'b1, 1'b0, 32'd5, 32'd3, 3'b000, 32'd0, 32'd0, 3'b000, 1'b0, 0, w, r, z);
        check("pre_reset_result", r, 32'd8);
        bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_op = 3'b000;
        @(posedge clk); #1;
        bus.req1_valid = 1'b1;
        #1;
        check("midop_busy_exec", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midop_reset_busy", 32'(bus.busy), 32'd0);
        check("midop_reset_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        check("midop_reset_result", bus.rsp_result, 32'd0);
        check("midop_reset_zero", 32'(bus.rsp_zero), 32'd0);
        check("midop_reset_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n      = 1'b1;
        model_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_reset_no_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid, bus.busy}), 32'd0);
        end
        issue(1'b1, 1'b1, 32'd1, 32'd1, 3'b000, 32'd10, 32'd10, 3'b000, 1'b0, 0, w, r, z);
        check("post_reset_tie_port0", r, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
